// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive-side bus controller.
// Captures bytes from a UART receiver via an rdy/done handshake into a
// receive FIFO and exposes DATA/STATUS/CTRL/COUNT registers on a simple
// sel/wr bus. Optional idle timeout flag is enabled with the macro
// UART_RX_CTRL_TIMEOUT_EN (default build: no timeout logic, tmo reads 0).
//
// Register map (addr):
//   0 DATA   read pops FIFO head (8'h00 when empty)
//   1 STATUS {3'b0, fsel, tmo, ovr, full, nempty}; write bit2/bit3 W1C
//   2 CTRL   {6'b0, irq_en, fsel}; write bit2=1 flushes FIFO
//   3 COUNT  FIFO occupancy, saturated to 8 bits

module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_fsel,
  output logic       irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          ovr;
  logic          fsel;
  logic          irq_en;
  logic          tmo;

  logic          nempty;
  logic          full;
  logic          rd_acc;
  logic          wr_acc;
  logic          pop;
  logic          flush;
  logic          push_req;
  logic          push_ok;
  logic          ovr_set;
  logic          ovr_clr;
  logic [8:0]    count_ext;

  // Bus decode and FIFO push/pop qualification
  always_comb begin
    nempty    = (count != '0);
    full      = (count == CW'(FIFO_DEPTH));
    rd_acc    = sel & ~wr;
    wr_acc    = sel & wr;
    pop       = rd_acc & (addr == 2'd0) & nempty;
    flush     = wr_acc & (addr == 2'd2) & wdata[2];
    push_req  = (state == IDLE) & rx_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok   = push_req & ~flush & (~full | pop);
    ovr_set   = push_req & ~flush & full & ~pop;
    ovr_clr   = wr_acc & (addr == 2'd1) & wdata[2];
    count_ext = 9'(count);
  end

  // Capture handshake FSM; rx_done is high exactly while in ACK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            state   <= ACK;
            rx_done <= 1'b1;
          end
        end
        ACK:      state <= WAIT_CLR;
        WAIT_CLR: if (!rx_rdy) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= rx_data;
  end

  // FIFO pointers and occupancy; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
    end
  end

  // Overrun sticky flag; set wins over write-1-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovr <= 1'b0;
    else if (ovr_set) ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end

  // Control register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsel   <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_acc && (addr == 2'd2)) begin
      fsel   <= wdata[0];
      irq_en <= wdata[1];
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr;
  logic          tmo_inc;
  logic          tmo_set;
  logic          tmo_w1c;
  logic          unused_wdata;

  // Idle-timeout qualification: count only quiet cycles with data waiting
  always_comb begin
    tmo_clr = push_req | pop | flush | ~nempty;
    tmo_inc = ~tmo_clr & (tmo_cnt != TW'(TIMEOUT_CYCLES));
    tmo_set = tmo_inc & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    tmo_w1c = wr_acc & (addr == 2'd1) & wdata[3];
  end

  // Timeout counter saturates at TIMEOUT_CYCLES; tmo is sticky, set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_set)      tmo <= 1'b1;
      else if (tmo_w1c) tmo <= 1'b0;
    end
  end

  assign unused_wdata = ^wdata[7:4];
`else
  logic unused_wdata;

  assign tmo          = 1'b0;
  assign unused_wdata = ^wdata[7:3];
`endif

  // Register read mux; combinational from addr and current state
  always_comb begin
    rdata = 8'h00;
    case (addr)
      2'd0: rdata = nempty ? mem[rptr] : 8'h00;
      2'd1: rdata = {3'b000, fsel, tmo, ovr, full, nempty};
      2'd2: rdata = {6'b000000, irq_en, fsel};
      2'd3: rdata = count_ext[8] ? 8'hFF : count_ext[7:0];
      default: rdata = 8'h00;
    endcase
  end

  // Outputs derived directly from registered state
  assign rx_fsel = fsel;
  assign irq     = irq_en & (nempty | ovr | tmo);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (FIFO_DEPTH=16, TIMEOUT_CYCLES=8).
// Expected FIFO contents live in a scoreboard queue filled when bytes are
// offered to the DUT and drained when DATA reads return them.

module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_fsel;
  logic       irq;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovr = 1'b0;

  uart_rx_ctrl #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
    .rx_fsel(rx_fsel), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Combinational register view without a bus access
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    sel = 1'b0; addr = a;
    #1 d = rdata;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 sel = 1'b0; wr = 1'b0;
  endtask

  // Receiver model: raise rx_rdy, wait for rx_done, drop rdy one cycle later
  task automatic send_byte(input logic [7:0] b);
    logic seen;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = b;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (rx_done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rx_done_seen got 0 exp 1 (byte %h)", b); end
    if (exp_q.size() < 16) exp_q.push_back(b);
    else exp_ovr = 1'b1;
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b0) begin fails++; $display("FAIL rx_done_width got %b exp 0", rx_done); end
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_rd(2'd0, d);
      tests++;
      if (d !== e) begin fails++; $display("FAIL %s_data got %h exp %h", tag, d, e); end
    end
    peek(2'd3, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL %s_count_after_drain got %h exp 00", tag, d); end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b0; sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 8'h00;
    rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if ({rx_done, rx_fsel, irq} !== 3'b000) begin
      fails++; $display("FAIL reset_outputs got %b exp 000", {rx_done, rx_fsel, irq});
    end
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), d);
      tests++;
      if (d !== 8'h00) begin fails++; $display("FAIL reset_reg%0d got %h exp 00", a, d); end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] d;
    logic [7:0] e;
    send_byte(8'hA5);
    peek(2'd1, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL single_status got %h exp 01", d); end
    e = exp_q.pop_front();
    bus_rd(2'd0, d);
    tests++;
    if (d !== e) begin fails++; $display("FAIL single_data got %h exp %h", d, e); end
    peek(2'd1, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL single_status_after got %h exp 00", d); end
  endtask

  task automatic test_hold;
    logic [7:0] d;
    int pulses;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'h3C;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_done === 1'b1) pulses++;
    end
    exp_q.push_back(8'h3C);
    rx_rdy = 1'b0;
    @(negedge clk);
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    peek(2'd3, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL hold_count got %h exp 01", d); end
    drain("hold");
  endtask

  task automatic test_empty_read;
    logic [7:0] d;
    bus_rd(2'd0, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL empty_read got %h exp 00", d); end
    peek(2'd3, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL empty_count got %h exp 00", d); end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    for (int i = 0; i <= 16; i++) send_byte(8'(i));
    peek(2'd3, d);
    tests++;
    if (d !== 8'd16) begin fails++; $display("FAIL ovf_count got %h exp 10", d); end
    peek(2'd1, d);
    tests++;
    if (d !== {5'b0, exp_ovr, 2'b11}) begin fails++; $display("FAIL ovf_status got %h exp 07", d); end
    bus_wr(2'd1, 8'h04);
    exp_ovr = 1'b0;
    peek(2'd1, d);
    tests++;
    if (d !== 8'h03) begin fails++; $display("FAIL ovf_w1c got %h exp 03", d); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] d;
    logic [7:0] e;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'h77;
    sel = 1'b1; wr = 1'b0; addr = 2'd0;
    #1 d = rdata;
    e = exp_q.pop_front();
    exp_q.push_back(8'h77);
    tests++;
    if (d !== e) begin fails++; $display("FAIL fullpp_head got %h exp %h", d, e); end
    @(posedge clk);
    #1 sel = 1'b0;
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b1) begin fails++; $display("FAIL fullpp_ack got %b exp 1", rx_done); end
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    peek(2'd3, d);
    tests++;
    if (d !== 8'd16) begin fails++; $display("FAIL fullpp_count got %h exp 10", d); end
    peek(2'd1, d);
    tests++;
    if (d !== 8'h03) begin fails++; $display("FAIL fullpp_status got %h exp 03", d); end
    drain("fullpp");
  endtask

  task automatic test_flush;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    bus_wr(2'd2, 8'h05);
    exp_q.delete();
    peek(2'd3, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL flush_count got %h exp 00", d); end
    peek(2'd1, d);
    tests++;
    if (d !== 8'h10) begin fails++; $display("FAIL flush_status got %h exp 10", d); end
    peek(2'd2, d);
    tests++;
    if (d !== 8'h01 || rx_fsel !== 1'b1) begin
      fails++; $display("FAIL flush_ctrl got %h/%b exp 01/1", d, rx_fsel);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    logic       exp_tmo;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif
    bus_wr(2'd2, 8'h03);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_empty got %b exp 0", irq); end
    send_byte(8'h99);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_nempty got %b exp 1", irq); end
    repeat (4) @(negedge clk);
    peek(2'd1, d);
    tests++;
    if (d[3] !== 1'b0) begin fails++; $display("FAIL tmo_early got %b exp 0", d[3]); end
    peek(2'd1, d);
    tests++;
    if (d[3] !== exp_tmo || irq !== 1'b1) begin
      fails++; $display("FAIL tmo_set got %b/%b exp %b/1", d[3], irq, exp_tmo);
    end
    bus_wr(2'd1, 8'h08);
    peek(2'd1, d);
    tests++;
    if (d[3] !== 1'b0) begin fails++; $display("FAIL tmo_w1c got %b exp 0", d[3]); end
    drain("tmo");
  endtask

  task automatic test_reset_mid_ack;
    logic [7:0] d;
    logic       seen;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b1) begin fails++; $display("FAIL rst_pre_ack got %b exp 1", rx_done); end
    rst = 1'b0;
    addr = 2'd3;
    #1;
    tests++;
    if ({rx_done, rx_fsel, irq} !== 3'b000 || rdata !== 8'h00) begin
      fails++; $display("FAIL rst_mid_ack got %b/%h exp 000/00", {rx_done, rx_fsel, irq}, rdata);
    end
    exp_q.delete();
    exp_ovr = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (rx_done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rst_recapture got 0 exp 1"); end
    exp_q.push_back(8'h5A);
    @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    peek(2'd3, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL rst_recapture_count got %h exp 01", d); end
    drain("rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_empty_read();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_timeout();
    test_reset_mid_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, idle clocks with FIFO non-empty before timeout flag sets.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 sel  in  1  bus access strobe, one cycle per access.
REQ-006 wr  in  1  1=write, 0=read; qualified by sel.
REQ-007 addr  in  2  register select.
REQ-008 wdata  in  8  write data.
REQ-009 rdata  out  8  read data; combinational from addr and current state.
REQ-010 rx_rdy  in  1  receiver byte-ready from UART receiver.
REQ-011 rx_data  in  8  receiver byte; valid while rx_rdy=1.
REQ-012 rx_done  out  1  one-cycle acknowledge to receiver ("byte read").
REQ-013 rx_fsel  out  1  receiver baud select, driven from CTRL.fsel.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Capture FSM SHALL have states IDLE, ACK, WAIT_CLR; IDLE->ACK when rx_rdy=1, pushing rx_data into FIFO on that edge.
REQ-016 In ACK, rx_done SHALL be 1 for exactly one cycle; ACK->WAIT_CLR unconditionally.
REQ-017 WAIT_CLR->IDLE when rx_rdy=0; no capture in WAIT_CLR, so each byte is pushed exactly once.
REQ-018 Push with FIFO full SHALL discard the byte, set STATUS.ovr, and still acknowledge.
REQ-019 Push and pop in the same cycle while full SHALL accept the push; count unchanged, no overrun.
REQ-020 addr 0 read (DATA): rdata=FIFO head; a read access (sel=1, wr=0) pops one entry when non-empty; empty FIFO returns 8'h00 and no pointer change.
REQ-021 addr 1 (STATUS) read: bit0 nempty, bit1 full, bit2 ovr, bit3 tmo, bit4 fsel, bits7:5 zero; write: bit2/bit3 write-1-to-clear.
REQ-022 addr 2 (CTRL) read/write: bit0 fsel, bit1 irq_en; write of bit2=1 flushes FIFO (pointers and count to 0) same edge, reads back 0.
REQ-023 Flush in the same cycle as a push SHALL win; byte discarded, ovr unchanged.
REQ-024 addr 3 read: FIFO count (saturating field width 8; DEPTH=256 full reads 8'hFF with full=1); writes ignored.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 irq = irq_en & (nempty | ovr | tmo).
REQ-027 Set and W1C of a sticky flag in the same cycle: set wins.

Reset
REQ-028 rst=0 SHALL immediately force: FSM IDLE, FIFO empty, ovr=0, tmo=0, fsel=0, irq_en=0, timeout counter 0.
REQ-029 Resulting outputs during reset: rx_done=0, rx_fsel=0, irq=0, rdata per addr with reset state.
REQ-030 Reset mid-handshake SHALL leave FSM in IDLE; a still-high rx_rdy after release is captured as a new byte.

Configuration
REQ-031 Macro UART_RX_CTRL_TIMEOUT_EN defined: counter increments each cycle FIFO non-empty and no push/pop; clears on push, pop, flush, or empty; reaching TIMEOUT_CYCLES sets tmo (sticky) and counter holds.
REQ-032 Macro undefined: no timeout counter logic; STATUS.bit3 reads 0, W1C ignored, tmo excluded from irq.

Verification
REQ-033 rx_rdy=1 with rx_data=8'hA5, drop rx_rdy 1 cycle after rx_done -> single rx_done pulse, STATUS=8'h01, DATA read returns 8'hA5, then STATUS=8'h00.
REQ-034 Hold rx_rdy=1 for 10 cycles with one byte -> exactly one push, count=1.
REQ-035 Push 17 bytes 8'h00..8'h10, no reads (DEPTH 16) -> count=16, full=1, ovr=1; reads return 8'h00..8'h0F; write STATUS 8'h04 clears ovr.
REQ-036 FIFO full, push and DATA read same cycle -> count stays 16, ovr=0, last pushed byte readable last.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=8, irq_en=1, one byte pushed, idle -> tmo=1 and irq=1 eight cycles after push; undefined macro -> tmo stays 0.
REQ-038 CTRL write 8'h05 with 3 bytes queued -> count=0, fsel=1, rx_fsel=1, CTRL reads 8'h01; assert rst mid-ACK -> rx_done=0 immediately.
